// File: rtl/button_debounce.sv
// button_debounce: per-channel two-flop synchroniser followed by a
// four-state debounce FSM. A channel's clean level changes only after the
// synchronised pin has held its new value for STABLE_CYCLES consecutive
// clocks; busy flags the channels currently qualifying a candidate change.
module button_debounce #(
    parameter int WIDTH         = 1,
    parameter int STABLE_CYCLES = 250000,
    parameter int CNT_W         = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] busy
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } state_t;

    // The last count value in a WAIT state; reaching it with the candidate
    // level still present commits the new level on that edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync_1;
    logic [WIDTH-1:0] sync_2;

    // Two-flop synchroniser: the raw pins are asynchronous, so nothing but
    // sync_2 may be looked at by the FSMs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values; blocking here would collapse the two stages.
        if (!reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= in;
            sync_2 <= sync_1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             level;
        logic             s;

        assign s = sync_2[g];

        // Debounce FSM: a candidate level must persist for STABLE_CYCLES
        // samples; any bounce back returns to the idle state with cnt cleared.
        always_ff @(posedge clk) begin
            if (!reset) begin
                state <= IDLE_LOW;
                cnt   <= '0;
                level <= 1'b0;
            end else begin
                unique case (state)
                    IDLE_LOW: begin
                        if (s) begin
                            state <= WAIT_HIGH;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    WAIT_HIGH: begin
                        if (!s) begin
                            state <= IDLE_LOW;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state <= IDLE_HIGH;
                            level <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    IDLE_HIGH: begin
                        if (!s) begin
                            state <= WAIT_LOW;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    WAIT_LOW: begin
                        if (s) begin
                            state <= IDLE_HIGH;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state <= IDLE_LOW;
                            level <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                        level <= 1'b0;
                    end
                endcase
            end
        end

        // busy is a pure decode of the state register, so it tracks the
        // WAIT states with no extra cycle of latency.
        assign busy[g] = (state == WAIT_HIGH) || (state == WAIT_LOW);
        assign out[g]  = level;
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with WIDTH=2, STABLE_CYCLES=4.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, so "edge k" below is the k-th rising edge after an input change.
module tb_button_debounce;

    localparam int WIDTH         = 2;
    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 18;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] busy;

    int passed = 0;
    int total  = 0;

    // one_pulse model on the debounced outputs: counts clean rising edges
    logic [WIDTH-1:0] out_prev = '0;
    int               pulses [WIDTH];

    typedef struct {
        logic             rst;
        logic [WIDTH-1:0] vin;
        logic [WIDTH-1:0] exp_out;
        logic [WIDTH-1:0] exp_busy;
        string            name;
    } vec_t;

    vec_t vecs[$];

    button_debounce #(
        .WIDTH(WIDTH),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in(in),
        .out(out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        else
            passed++;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp)
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else
            passed++;
    endtask

    // Advance one clock edge and sample 1 ns later; also runs the pulse model.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < WIDTH; i++)
            if (out[i] === 1'b1 && out_prev[i] !== 1'b1) pulses[i]++;
        out_prev = out;
    endtask

    task automatic add(input logic r, input logic [1:0] vi, input logic [1:0] eo,
                       input logic [1:0] eb, input string nm);
        vec_t v;
        v.rst = r; v.vin = vi; v.exp_out = eo; v.exp_busy = eb; v.name = nm;
        vecs.push_back(v);
    endtask

    int p0_base, p1_base;

    initial begin
        for (int i = 0; i < WIDTH; i++) pulses[i] = 0;
        reset = 1'b0;
        in    = 2'b11;
        #2;

        // Reset held 3 cycles with both pins high, then release.
        for (int i = 0; i < 3; i++) add(1'b0, 2'b11, 2'b00, 2'b00, "reset_hold");
        add(1'b1, 2'b11, 2'b00, 2'b00, "rel_e0");
        add(1'b1, 2'b11, 2'b00, 2'b00, "rel_e1");
        add(1'b1, 2'b11, 2'b00, 2'b11, "rel_e2");
        add(1'b1, 2'b11, 2'b00, 2'b11, "rel_e3");
        add(1'b1, 2'b11, 2'b00, 2'b11, "rel_e4");
        add(1'b1, 2'b11, 2'b11, 2'b00, "rel_e5");
        // Release channel 0.
        add(1'b1, 2'b10, 2'b11, 2'b00, "off0_e0");
        add(1'b1, 2'b10, 2'b11, 2'b00, "off0_e1");
        add(1'b1, 2'b10, 2'b11, 2'b01, "off0_e2");
        add(1'b1, 2'b10, 2'b11, 2'b01, "off0_e3");
        add(1'b1, 2'b10, 2'b11, 2'b01, "off0_e4");
        add(1'b1, 2'b10, 2'b10, 2'b00, "off0_e5");
        // Clean press on channel 0.
        add(1'b1, 2'b11, 2'b10, 2'b00, "press_e0");
        add(1'b1, 2'b11, 2'b10, 2'b00, "press_e1");
        add(1'b1, 2'b11, 2'b10, 2'b01, "press_e2");
        add(1'b1, 2'b11, 2'b10, 2'b01, "press_e3");
        add(1'b1, 2'b11, 2'b10, 2'b01, "press_e4");
        add(1'b1, 2'b11, 2'b11, 2'b00, "press_e5");

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            in    = vecs[i].vin;
            tick();
            check($sformatf("%s_out", vecs[i].name), out, vecs[i].exp_out);
            check($sformatf("%s_busy", vecs[i].name), busy, vecs[i].exp_busy);
        end

        // Bounce: ch0 high 3 cycles only, then low -> rejected.
        in = 2'b10;
        repeat (6) tick();
        check("bounce_pre_out", out, 2'b10);
        in = 2'b11;
        repeat (3) tick();
        in = 2'b10;
        tick();
        tick();
        check("bounce_e4_busy", busy, 2'b01);
        tick();
        check("bounce_e5_out", out, 2'b10);
        check("bounce_e5_busy", busy, 2'b00);
        repeat (2) tick();
        // Then held high: out rises on edge 5 after the final rise.
        in = 2'b11;
        repeat (5) tick();
        check("rise_e4_out", out, 2'b10);
        tick();
        check("rise_e5_out", out, 2'b11);
        check("rise_e5_busy", busy, 2'b00);

        // Release from out[0]=1.
        in = 2'b10;
        repeat (5) tick();
        check("release_e4_out", out, 2'b11);
        tick();
        check("release_e5_out", out, 2'b10);
        // 1-cycle glitch while IDLE_LOW.
        in = 2'b11;
        tick();
        in = 2'b10;
        tick();
        check("glitch_e1_busy", busy, 2'b00);
        tick();
        check("glitch_e2_busy", busy, 2'b01);
        tick();
        check("glitch_e3_busy", busy, 2'b00);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("glitch_out_%0d", i), out, 2'b10);
        end

        // Reset in the middle of a qualification (cnt=2).
        in = 2'b11;
        repeat (3) tick();
        check("midwait_e2_busy", busy, 2'b01);
        tick();
        reset = 1'b0;
        tick();
        check("midwait_rst_out", out, 2'b00);
        check("midwait_rst_busy", busy, 2'b00);
        reset = 1'b1;
        repeat (5) tick();
        check("midwait_e4_out", out, 2'b00);
        check("midwait_e4_busy", busy, 2'b11);
        tick();
        check("midwait_e5_out", out, 2'b11);

        // Independence: ch0 toggles every 2 cycles, ch1 held high.
        reset = 1'b0;
        in    = 2'b00;
        tick();
        reset   = 1'b1;
        p0_base = pulses[0];
        p1_base = pulses[1];
        for (int j = 0; j < 20; j++) begin
            in = {1'b1, ((j / 2) % 2 == 0)};
            tick();
            check($sformatf("indep_out0_%0d", j), {1'b0, out[0]}, 2'b00);
            if (j == 4) check("indep_e4_out1", {1'b0, out[1]}, 2'b00);
            if (j == 5) check("indep_e5_out1", {1'b0, out[1]}, 2'b01);
        end
        check_int("indep_pulses_ch1", pulses[1] - p1_base, 1);
        check_int("indep_pulses_ch0", pulses[0] - p0_base, 0);
        in = 2'b11;
        repeat (8) tick();
        check("indep_final_out", out, 2'b11);
        check_int("press_pulses_ch0", pulses[0] - p0_base, 1);
        check_int("press_pulses_ch1", pulses[1] - p1_base, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
